tx_burst_scheduler: RTL and testbench
=====================================

Name: tx_burst_scheduler

Overview:
Sequences the PRBS transmitter in the Red Pitaya DAC core. The block drives the 32-bit tx_cfg word that controls the mul_lfsr generator: srst, en, divider, repetition and order fields. It runs a programmed number of bursts, each optionally gated by an external trigger and separated by a programmable gap. It watches tx_flag from the DAC core to detect the end of each burst and reports progress and status to the PS register bank.

Parameters:
CNT_WIDTH, 16, width of the burst count and burst index.
GAP_WIDTH, 32, width of the inter-burst gap counter, in aclk cycles.
SRST_CYCLES, 4, number of cycles srst is held before the first burst (must be ≥1).
TIMEOUT_WIDTH, 24, width of the watchdog that waits for the first tx_flag rise in a burst.

Ports:
aclk  in  1  system clock (DAC aclk domain)
arst  in  1  asynchronous active-high reset
start_i  in  1  single-cycle start pulse
stop_i  in  1  single-cycle abort pulse
trig_i  in  1  external trigger, synchronous to aclk, level
cfg_sel_div_i  in  8  LFSR divider select
cfg_rep_i  in  3  repetition field
cfg_order_i  in  3  LFSR order field
cfg_count_i  in  CNT_WIDTH  number of bursts
cfg_gap_i  in  GAP_WIDTH  gap length between bursts
cfg_ext_trig_i  in  1  1 = each burst waits for a trig_i rising edge
cfg_timeout_i  in  TIMEOUT_WIDTH  watchdog limit, 0 = disabled
tx_flag_i  in  1  burst-active flag from the DAC core
tx_cfg_o  out  32  [7:0] sel_div, [10:8] rep, [13:11] order, [14] en, [15] srst, [31:16] 0
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse on normal completion
err_o  out  1  sticky timeout error, cleared by the next accepted start
burst_idx_o  out  CNT_WIDTH  number of completed bursts

Behaviour:
- Reset (async, arst=1): state=IDLE; tx_cfg_o=32'h0000_8000 (srst=1, en=0, fields 0); busy_o=0; done_o=0; err_o=0; burst_idx_o=0.
- All outputs are registered and update on the same aclk edge as the state.
- States: IDLE, SRST, ARM, RUN, GAP, DONE.
- Field latching: cfg_sel_div_i, cfg_rep_i, cfg_order_i, cfg_count_i, cfg_gap_i, cfg_ext_trig_i and cfg_timeout_i are latched when start is accepted. Changes on these inputs during operation are ignored.
- IDLE: srst=1, en=0.
  - start_i with count≠0 → SRST; clear burst_idx and err.
  - start_i with count=0 → DONE directly; no burst is run.
- SRST: srst=1, en=0 for exactly SRST_CYCLES cycles → ARM.
- ARM: srst=0, en=0.
  - ext_trig=0 → RUN on the next cycle.
  - ext_trig=1 → wait for a trig_i rising edge (trig_i=1 and the previous sample=0), then RUN.
  - A trigger already high on entry does not count.
- RUN: srst=0, en=1.
  - seen_rise is cleared on entry and set when tx_flag_i=1.
  - A tx_flag_i falling edge with seen_rise=1 increments burst_idx. If the new idx equals count → DONE, else → GAP.
  - Watchdog counts cycles while seen_rise=0. When it reaches a nonzero cfg_timeout → set err, go to DONE.
- GAP: srst=1, en=0 for cfg_gap+1 cycles (gap=0 gives 1 cycle) → ARM. Every burst restarts the LFSR from its seed.
- DONE: one cycle. done_o=1, srst=1, en=0 → IDLE.
- stop_i in any non-IDLE state → IDLE on the next edge. tx_cfg_o returns to srst=1, en=0. No done pulse; burst_idx holds its value.
- Priorities:
  - stop_i beats every other transition in the same cycle.
  - start_i while busy is ignored.
  - Simultaneous flag fall and watchdog expiry: the flag fall wins.
- Counters do not wrap: burst_idx ≤ count ≤ 2^CNT_WIDTH−1. The gap counter is GAP_WIDTH bits and saturates at load value compare.

Optional Feature:
TX_BURST_TIMESTAMP_EN
- Defined: adds a free-running 32-bit cycle counter (reset 0, wraps at 2^32). Adds outputs ts_o[31:0] and ts_valid_o.
  - On each ARM→RUN transition, ts_o latches the counter value and ts_valid_o pulses for one cycle.
  - Reset values: ts_o=0, ts_valid_o=0.
- Undefined: no counter and no extra ports; behaviour is otherwise identical.

Test Plan:
1. Reset, then start with count=3, gap=10, ext_trig=0; model tx_flag high for 20 cycles per burst.
   Required: tx_cfg_o[15] high for 4 cycles, then [14] high. burst_idx steps 1,2,3. GAP lasts 11 cycles each with [15]=1. done_o pulses once, busy_o falls the next cycle.
2. ext_trig=1, trig_i already high at ARM entry.
   Required: no RUN until trig_i goes 0 then 1. en rises exactly one cycle after the rising edge.
3. timeout=50, tx_flag_i held 0.
   Required: after 50 RUN cycles, err_o=1 and done_o pulses. The next start clears err_o.
4. stop_i during RUN of burst 2 of 5.
   Required: next cycle tx_cfg_o=32'h0000_8xxx with en=0, busy_o=0, burst_idx_o=1, no done pulse. start_i in the same cycle as stop_i is ignored.
5. start with count=0.
   Required: done_o pulses 1 cycle later, en never asserted. Field check with sel_div=8'hA5, rep=3'd5, order=3'd6: tx_cfg_o[13:0]=14'h35A5 while in RUN.
6. Built with TX_BURST_TIMESTAMP_EN, count=2.
   Required: two ts_valid_o pulses. The ts_o difference equals the burst length plus gap, plus 1 ARM cycle, plus 1.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// tx_burst_scheduler: drives the mul_lfsr tx_cfg word through counted, gapped, optionally triggered bursts.
// Define TX_BURST_TIMESTAMP_EN to add a free-running cycle counter and per-burst start timestamps.
//
// state | meaning
// IDLE  | waiting for start, LFSR held in srst
// SRST  | srst held for SRST_CYCLES before the first burst
// ARM   | srst released, waiting for an optional trigger edge
// RUN   | en=1, waiting for tx_flag to rise and then fall
// GAP   | srst held for cfg_gap+1 cycles between bursts
// DONE  | one-cycle completion pulse
module tx_burst_scheduler #(
  parameter int CNT_WIDTH     = 16,
  parameter int GAP_WIDTH     = 32,
  parameter int SRST_CYCLES   = 4,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     trig_i,
  input  logic [7:0]               cfg_sel_div_i,
  input  logic [2:0]               cfg_rep_i,
  input  logic [2:0]               cfg_order_i,
  input  logic [CNT_WIDTH-1:0]     cfg_count_i,
  input  logic [GAP_WIDTH-1:0]     cfg_gap_i,
  input  logic                     cfg_ext_trig_i,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout_i,
  input  logic                     tx_flag_i,
  output logic [31:0]              tx_cfg_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [CNT_WIDTH-1:0]     burst_idx_o
`ifdef TX_BURST_TIMESTAMP_EN
  ,
  output logic [31:0]              ts_o,
  output logic                     ts_valid_o
`endif
);

  typedef enum logic [2:0] {IDLE, SRST, ARM, RUN, GAP, DONE} state_t;

  state_t r_state, w_state_n;

  logic [7:0]               r_sel_div;
  logic [2:0]               r_rep;
  logic [2:0]               r_order;
  logic [CNT_WIDTH-1:0]     r_count;
  logic [CNT_WIDTH-1:0]     r_idx;
  logic [GAP_WIDTH-1:0]     r_gap;
  logic [GAP_WIDTH-1:0]     r_tmr;
  logic                     r_ext_trig;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [TIMEOUT_WIDTH-1:0] r_wdog;
  logic                     r_trig_prev;
  logic                     r_flag_prev;
  logic                     r_seen_rise;
  logic [31:0]              r_tx_cfg;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_fall;
  logic                     w_wdog_exp;
  logic                     w_idx_inc;
  logic                     w_set_err;
  logic                     w_enter_run;
  logic                     w_enter_gap;
  logic [CNT_WIDTH-1:0]     w_idx_p1;
  logic [7:0]               w_sel_div;
  logic [2:0]               w_rep;
  logic [2:0]               w_order;
  logic                     w_srst;
  logic                     w_en;

  assign w_idx_p1   = r_idx + CNT_WIDTH'(1);
  // A fall only counts once the flag has been seen high inside this RUN visit.
  assign w_fall     = r_flag_prev & ~tx_flag_i & r_seen_rise;
  assign w_wdog_exp = ~r_seen_rise & (r_timeout != '0) & (r_wdog == '0);

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_idx_inc = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept  = 1'b1;
          w_state_n = (cfg_count_i == '0) ? DONE : SRST;
        end
      end
      SRST: if (r_tmr == '0) w_state_n = ARM;
      ARM:  if (!r_ext_trig || (trig_i && !r_trig_prev)) w_state_n = RUN;
      RUN: begin
        if (w_fall) begin
          w_idx_inc = 1'b1;
          w_state_n = (w_idx_p1 == r_count) ? DONE : GAP;
        end else if (w_wdog_exp) begin
          w_set_err = 1'b1;
          w_state_n = DONE;
        end
      end
      GAP:  if (r_tmr == '0) w_state_n = ARM;
      DONE: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (stop_i && (r_state != IDLE)) begin
      w_state_n = IDLE;
      w_idx_inc = 1'b0;
      w_set_err = 1'b0;
    end
  end

  assign w_enter_run = (w_state_n == RUN) && (r_state != RUN);
  assign w_enter_gap = (w_state_n == GAP) && (r_state != GAP);
  assign w_sel_div   = w_accept ? cfg_sel_div_i : r_sel_div;
  assign w_rep       = w_accept ? cfg_rep_i     : r_rep;
  assign w_order     = w_accept ? cfg_order_i   : r_order;
  assign w_en        = (w_state_n == RUN);
  assign w_srst      = (w_state_n != ARM) && (w_state_n != RUN);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state     <= IDLE;
      r_sel_div   <= '0;
      r_rep       <= '0;
      r_order     <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_tmr       <= '0;
      r_ext_trig  <= 1'b0;
      r_timeout   <= '0;
      r_wdog      <= '0;
      r_trig_prev <= 1'b0;
      r_flag_prev <= 1'b0;
      r_seen_rise <= 1'b0;
      r_tx_cfg    <= 32'h0000_8000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_trig_prev <= trig_i;
      r_flag_prev <= tx_flag_i;

      if (w_accept) begin
        r_sel_div  <= cfg_sel_div_i;
        r_rep      <= cfg_rep_i;
        r_order    <= cfg_order_i;
        r_count    <= cfg_count_i;
        r_gap      <= cfg_gap_i;
        r_ext_trig <= cfg_ext_trig_i;
        r_timeout  <= cfg_timeout_i;
        r_idx      <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_idx_inc) r_idx <= w_idx_p1;
        if (w_set_err) r_err <= 1'b1;
      end

      // Shared down-counter: SRST hold length, then each inter-burst gap.
      if (w_accept)
        r_tmr <= GAP_WIDTH'(SRST_CYCLES - 1);
      else if (w_enter_gap)
        r_tmr <= r_gap;
      else if (r_tmr != '0)
        r_tmr <= r_tmr - GAP_WIDTH'(1);

      if (w_enter_run) begin
        r_seen_rise <= 1'b0;
        r_wdog      <= r_timeout - TIMEOUT_WIDTH'(1);
      end else if (r_state == RUN) begin
        if (tx_flag_i) r_seen_rise <= 1'b1;
        if (!r_seen_rise && (r_wdog != '0)) r_wdog <= r_wdog - TIMEOUT_WIDTH'(1);
      end

      r_tx_cfg <= {16'h0000, w_srst, w_en, w_order, w_rep, w_sel_div};
      r_busy   <= (w_state_n != IDLE);
      r_done   <= (w_state_n == DONE);
    end
  end

  assign tx_cfg_o    = r_tx_cfg;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign burst_idx_o = r_idx;

`ifdef TX_BURST_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_ts;
  logic        r_ts_valid;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_ts_cnt   <= '0;
      r_ts       <= '0;
      r_ts_valid <= 1'b0;
    end else begin
      r_ts_cnt   <= r_ts_cnt + 32'd1;
      r_ts_valid <= (r_state == ARM) && (w_state_n == RUN);
      if ((r_state == ARM) && (w_state_n == RUN)) r_ts <= r_ts_cnt;
    end
  end

  assign ts_o       = r_ts;
  assign ts_valid_o = r_ts_valid;
`endif

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed bench for tx_burst_scheduler; outputs sampled on the falling edge, inputs driven there too.
// The timestamp scenario runs only when TX_BURST_TIMESTAMP_EN is defined.
module tb_tx_burst_scheduler;
  localparam int CW = 16;
  localparam int GW = 32;
  localparam int TW = 24;

  logic          aclk = 1'b0;
  logic          arst;
  logic          start_i, stop_i, trig_i;
  logic [7:0]    cfg_sel_div_i;
  logic [2:0]    cfg_rep_i, cfg_order_i;
  logic [CW-1:0] cfg_count_i;
  logic [GW-1:0] cfg_gap_i;
  logic          cfg_ext_trig_i;
  logic [TW-1:0] cfg_timeout_i;
  logic          tx_flag_i;
  logic [31:0]   tx_cfg_o;
  logic          busy_o, done_o, err_o;
  logic [CW-1:0] burst_idx_o;
`ifdef TX_BURST_TIMESTAMP_EN
  logic [31:0]   ts_o;
  logic          ts_valid_o;
`endif

  int total = 0;
  int bad   = 0;

  tx_burst_scheduler dut (
    .aclk(aclk), .arst(arst), .start_i(start_i), .stop_i(stop_i), .trig_i(trig_i),
    .cfg_sel_div_i(cfg_sel_div_i), .cfg_rep_i(cfg_rep_i), .cfg_order_i(cfg_order_i),
    .cfg_count_i(cfg_count_i), .cfg_gap_i(cfg_gap_i), .cfg_ext_trig_i(cfg_ext_trig_i),
    .cfg_timeout_i(cfg_timeout_i), .tx_flag_i(tx_flag_i), .tx_cfg_o(tx_cfg_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .burst_idx_o(burst_idx_o)
`ifdef TX_BURST_TIMESTAMP_EN
    , .ts_o(ts_o), .ts_valid_o(ts_valid_o)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic abort();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tick();
  endtask

  task automatic wait_en(input int budget, output int cycles);
    cycles = 0;
    while (tx_cfg_o[14] !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // Flag high for 20 samples starting at the current one, then low; ends one sample after the fall.
  task automatic flag_burst();
    tx_flag_i = 1'b1;
    repeat (20) tick();
    tx_flag_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    arst = 1'b1; start_i = 0; stop_i = 0; trig_i = 0; tx_flag_i = 0;
    cfg_sel_div_i = 0; cfg_rep_i = 0; cfg_order_i = 0; cfg_count_i = 0;
    cfg_gap_i = 0; cfg_ext_trig_i = 0; cfg_timeout_i = 0;
    repeat (3) tick();
    total++; if (tx_cfg_o !== 32'h0000_8000) begin bad++; $display("FAIL reset_cfg: got %h want 00008000", tx_cfg_o); end
    total++; if ({busy_o, done_o, err_o} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy_o, done_o, err_o}); end
    total++; if (burst_idx_o !== 16'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", burst_idx_o); end
    arst = 1'b0;
    repeat (2) tick();
    total++; if (tx_cfg_o !== 32'h0000_8000 || busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_idle: cfg %h busy %b", tx_cfg_o, busy_o); end
  endtask

  task automatic test_bursts();
    int n;
    int dones;
    cfg_count_i = 16'd3; cfg_gap_i = 32'd10; cfg_ext_trig_i = 0; cfg_timeout_i = 0;
    cfg_sel_div_i = 8'h11; cfg_rep_i = 3'd1; cfg_order_i = 3'd2;
    pulse_start();
    dones = 0;
    n = 0;
    while (busy_o === 1'b1 && tx_cfg_o[15] === 1'b1 && n < 20) begin n++; tick(); end
    total++; if (n !== 4) begin bad++; $display("FAIL srst_len: got %0d want 4", n); end
    total++; if (tx_cfg_o[15:14] !== 2'b00) begin bad++; $display("FAIL first_arm: got %b want 00", tx_cfg_o[15:14]); end
    tick();
    total++; if (tx_cfg_o !== 32'h0000_5111) begin bad++; $display("FAIL run_cfg: got %h want 00005111", tx_cfg_o); end
    for (int b = 1; b <= 3; b++) begin
      total++; if (tx_cfg_o[15:14] !== 2'b01) begin bad++; $display("FAIL run_en b%0d: got %b want 01", b, tx_cfg_o[15:14]); end
      tx_flag_i = 1'b1;
      repeat (20) begin tick(); dones += int'(done_o); end
      tx_flag_i = 1'b0;
      tick(); dones += int'(done_o);
      total++; if (burst_idx_o !== 16'(b)) begin bad++; $display("FAIL burst_idx: got %0d want %0d", burst_idx_o, b); end
      if (b < 3) begin
        n = 0;
        while (tx_cfg_o[15] === 1'b1 && n < 30) begin n++; tick(); dones += int'(done_o); end
        total++; if (n !== 11) begin bad++; $display("FAIL gap_len b%0d: got %0d want 11", b, n); end
        total++; if (tx_cfg_o[15:14] !== 2'b00) begin bad++; $display("FAIL gap_arm b%0d: got %b want 00", b, tx_cfg_o[15:14]); end
        tick(); dones += int'(done_o);
      end else begin
        total++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL done_pulse: done %b busy %b want 1 1", done_o, busy_o); end
        tick(); dones += int'(done_o);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_fall: got %b want 0", busy_o); end
      end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL done_count: got %0d want 1", dones); end
  endtask

  task automatic test_trigger();
    cfg_count_i = 16'd1; cfg_ext_trig_i = 1'b1; cfg_gap_i = 0; cfg_timeout_i = 0;
    trig_i = 1'b1;
    tick();
    pulse_start();
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      total++; if (tx_cfg_o[15:14] !== 2'b00) begin bad++; $display("FAIL trig_held_arm %0d: got %b want 00", i, tx_cfg_o[15:14]); end
      tick();
    end
    trig_i = 1'b0;
    tick(); tick();
    trig_i = 1'b1;
    total++; if (tx_cfg_o[14] !== 1'b0) begin bad++; $display("FAIL trig_pre_edge: en %b want 0", tx_cfg_o[14]); end
    tick();
    total++; if (tx_cfg_o[15:14] !== 2'b01) begin bad++; $display("FAIL trig_en_latency: got %b want 01", tx_cfg_o[15:14]); end
    abort();
    trig_i = 1'b0;
    cfg_ext_trig_i = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    cfg_count_i = 16'd1; cfg_timeout_i = 24'd50; tx_flag_i = 1'b0;
    pulse_start();
    wait_en(20, n);
    total++; if (n >= 20) begin bad++; $display("FAIL to_wait_en: got %0d cycles want <20", n); end
    n = 0;
    while (tx_cfg_o[14] === 1'b1 && n < 100) begin n++; tick(); end
    total++; if (n !== 50) begin bad++; $display("FAIL to_run_len: got %0d want 50", n); end
    total++; if ({err_o, done_o} !== 2'b11) begin bad++; $display("FAIL to_err_done: got %b want 11", {err_o, done_o}); end
    tick();
    total++; if ({err_o, busy_o} !== 2'b10) begin bad++; $display("FAIL to_sticky: err,busy %b want 10", {err_o, busy_o}); end
    cfg_timeout_i = 24'd0;
    pulse_start();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_err_clear: got %b want 0", err_o); end
    abort();
  endtask

  task automatic test_stop();
    int n;
    cfg_count_i = 16'd5; cfg_gap_i = 32'd2; cfg_timeout_i = 0;
    cfg_sel_div_i = 8'h3C; cfg_rep_i = 3'd0; cfg_order_i = 3'd0;
    pulse_start();
    wait_en(20, n);
    flag_burst();
    wait_en(30, n);
    total++; if (n >= 30) begin bad++; $display("FAIL stop_wait_b2: got %0d cycles want <30", n); end
    repeat (3) tick();
    stop_i = 1'b1; start_i = 1'b1;
    tick();
    stop_i = 1'b0; start_i = 1'b0;
    total++; if (tx_cfg_o[31:12] !== 20'h00008) begin bad++; $display("FAIL stop_cfg: got %h want 00008xxx", tx_cfg_o); end
    total++; if ({busy_o, done_o} !== 2'b00) begin bad++; $display("FAIL stop_flags: busy,done %b want 00", {busy_o, done_o}); end
    total++; if (burst_idx_o !== 16'd1) begin bad++; $display("FAIL stop_idx: got %0d want 1", burst_idx_o); end
    tick();
    total++; if ({busy_o, done_o} !== 2'b00) begin bad++; $display("FAIL stop_start_ignored: busy,done %b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_count_zero();
    int n;
    cfg_count_i = 16'd0; cfg_sel_div_i = 8'hA5; cfg_rep_i = 3'd5; cfg_order_i = 3'd6;
    pulse_start();
    total++; if ({done_o, tx_cfg_o[15:14]} !== 3'b110) begin bad++; $display("FAIL zero_done: done,srst,en %b want 110", {done_o, tx_cfg_o[15:14]}); end
    tick();
    total++; if ({done_o, busy_o, tx_cfg_o[14]} !== 3'b000) begin bad++; $display("FAIL zero_idle: done,busy,en %b want 000", {done_o, busy_o, tx_cfg_o[14]}); end
    cfg_count_i = 16'd1;
    pulse_start();
    cfg_sel_div_i = 8'h00; cfg_rep_i = 3'd0; cfg_order_i = 3'd0;
    wait_en(20, n);
    total++; if (tx_cfg_o[13:0] !== 14'h35A5) begin bad++; $display("FAIL field_pack: got %h want 35a5", tx_cfg_o[13:0]); end
    abort();
  endtask

`ifdef TX_BURST_TIMESTAMP_EN
  task automatic test_timestamp();
    int n;
    logic [31:0] t1;
    cfg_count_i = 16'd2; cfg_gap_i = 32'd3; cfg_ext_trig_i = 0; cfg_timeout_i = 0;
    pulse_start();
    wait_en(20, n);
    total++; if (ts_valid_o !== 1'b1) begin bad++; $display("FAIL ts_valid_1: got %b want 1", ts_valid_o); end
    t1 = ts_o;
    flag_burst();
    total++; if (ts_valid_o !== 1'b0) begin bad++; $display("FAIL ts_valid_low: got %b want 0", ts_valid_o); end
    wait_en(30, n);
    total++; if (ts_valid_o !== 1'b1) begin bad++; $display("FAIL ts_valid_2: got %b want 1", ts_valid_o); end
    // 21 RUN cycles + (gap 3) + 1 + 1 ARM cycle
    total++; if (ts_o - t1 !== 32'd26) begin bad++; $display("FAIL ts_delta: got %0d want 26", ts_o - t1); end
    flag_burst();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_bursts();
    test_trigger();
    test_timeout();
    test_stop();
    test_count_zero();
`ifdef TX_BURST_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
